// File: rtl/amstrad_mem_arbiter.sv
// Arbitrates the single external memory port between video fetch, Z80 CPU and Plus ASIC sound DMA.
// Fixed priority VID > CPU > DMA, with DMA promotion after repeated CPU wins and a per-transaction timeout.
module amstrad_mem_arbiter #(
    parameter int AW         = 23,
    parameter int DMA_STARVE = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [15:0]   vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic [15:0]   dma_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    output logic [1:0]    grant,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_VID  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_DMA  = 2'd3;

    localparam logic [2:0] STARVE_MAX = 3'(DMA_STARVE);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [1:0]  winner;
    logic [1:0]  owner_q;
    logic [2:0]  starve_cnt;
    logic [7:0]  tmo_cnt;
    logic        abort_q;
    logic        timeout_hit;
    logic [15:0] done_data;

    assign timeout_hit = (tmo_cnt == TMO_LAST);
    assign done_data   = mem_ack ? mem_rdata : 16'hFFFF;

    // DMA jumps ahead of the CPU only once it has watched STARVE_MAX CPU grants go by.
    always_comb begin
        winner = G_NONE;
        if (vid_req)
            winner = G_VID;
        else if (cpu_req && !(dma_req && starve_cnt == STARVE_MAX))
            winner = G_CPU;
        else if (dma_req)
            winner = G_DMA;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (winner != G_NONE) state_nxt = S_WAIT;
            S_WAIT:  if (mem_ack || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // The request is captured once in IDLE so the downstream port stays stable through WAIT,
    // even if the requester drops its req early.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= G_NONE;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            abort_q    <= 1'b0;
            vid_rdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (winner != G_NONE) begin
                        owner_q   <= winner;
                        mem_addr  <= (winner == G_VID) ? vid_addr :
                                     (winner == G_CPU) ? cpu_addr : dma_addr;
                        mem_we    <= (winner == G_CPU) && cpu_we;
                        mem_wdata <= (winner == G_CPU) ? cpu_wdata : 8'h00;
                    end
                    if (!dma_req || winner == G_DMA)
                        starve_cnt <= '0;
                    else if (winner == G_CPU && starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + 3'd1;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    abort_q <= !mem_ack && timeout_hit;
                    if (mem_ack || timeout_hit) begin
                        case (owner_q)
                            G_VID:   vid_rdata <= done_data;
                            G_CPU:   cpu_rdata <= mem_addr[0] ? done_data[15:8] : done_data[7:0];
                            G_DMA:   dma_rdata <= done_data;
                            default: ;
                        endcase
                    end
                end
                S_DONE:  tmo_cnt <= '0;
                default: tmo_cnt <= '0;
            endcase
        end
    end

    assign mem_req = (state == S_WAIT);
    assign grant   = (state == S_IDLE) ? G_NONE : owner_q;
    assign vid_ack = (state == S_DONE) && (owner_q == G_VID);
    assign cpu_ack = (state == S_DONE) && (owner_q == G_CPU);
    assign dma_ack = (state == S_DONE) && (owner_q == G_DMA);
    assign err     = (state == S_DONE) && abort_q;

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Self-checking bench for amstrad_mem_arbiter: directed vector table, reset-in-WAIT sequence,
// then randomized traffic against a transaction-level model of the arbitration rules.
module tb_amstrad_mem_arbiter;

    localparam int AW         = 23;
    localparam int DMA_STARVE = 4;
    localparam int TIMEOUT    = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          mem_ack = 1'b0;
    logic [15:0]   mem_rdata = '0;
    logic          vid_ack, cpu_ack, dma_ack, mem_req, mem_we, err;
    logic [15:0]   vid_rdata, dma_rdata;
    logic [7:0]    cpu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    int tests = 0;
    int fails = 0;
    int model_starve = 0;

    typedef struct {
        logic [2:0]  raise;
        logic        we;
        logic        lane;
        int          delay;
        logic [15:0] mdata;
        logic [1:0]  eg;
        logic [15:0] erd;
        logic        eerr;
        int          ewait;
    } vec_t;

    vec_t tbl[10];

    amstrad_mem_arbiter #(.AW(AW), .DMA_STARVE(DMA_STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raises the masked requests (vid, cpu, dma) that are not already pending; pending ones keep their fields.
    task automatic apply_stimulus(input logic [2:0] raise, input logic we, input logic [AW-1:0] caddr,
                                  input logic [7:0] wd, input logic [AW-1:0] vaddr, input logic [AW-1:0] daddr);
        if (raise[2] && !vid_req) begin vid_req = 1'b1; vid_addr = vaddr; end
        if (raise[1] && !cpu_req) begin cpu_req = 1'b1; cpu_we = we; cpu_addr = caddr; cpu_wdata = wd; end
        if (raise[0] && !dma_req) begin dma_req = 1'b1; dma_addr = daddr; end
    endtask

    // Called at an IDLE negedge with requests set; plays the memory side and ends at the next IDLE negedge.
    task automatic serve(input logic [1:0] eg, input int delay, input logic [15:0] mdata,
                         input logic eerr, input logic [15:0] erd, input int ewait);
        int            waits = 0;
        logic [AW-1:0] eaddr;
        logic          ewe;
        logic [7:0]    ewd;
        logic [2:0]    eack;
        eaddr = (eg == 2'd1) ? vid_addr : (eg == 2'd2) ? cpu_addr : dma_addr;
        ewe   = (eg == 2'd2) && cpu_we;
        ewd   = (eg == 2'd2) ? cpu_wdata : 8'h00;
        eack  = (eg == 2'd1) ? 3'b100 : (eg == 2'd2) ? 3'b010 : 3'b001;
        @(negedge clk);
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            if (!mem_req) break;
            check_output("wait_grant", 64'(grant), 64'(eg));
            check_output("wait_bus", 64'({mem_addr, mem_we, mem_wdata}), 64'({eaddr, ewe, ewd}));
            mem_ack   = (i == delay);
            mem_rdata = (i == delay) ? mdata : 16'($urandom);
            waits++;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check_output("wait_len", 64'(waits), 64'(ewait));
        check_output("done_ack", 64'({vid_ack, cpu_ack, dma_ack}), 64'(eack));
        check_output("done_grant", 64'(grant), 64'(eg));
        check_output("done_err", 64'(err), 64'(eerr));
        case (eg)
            2'd1:    check_output("vid_rdata", 64'(vid_rdata), 64'(erd));
            2'd2:    check_output("cpu_rdata", 64'(cpu_rdata), 64'(erd[7:0]));
            default: check_output("dma_rdata", 64'(dma_rdata), 64'(erd));
        endcase
        case (eg)
            2'd1:    vid_req = 1'b0;
            2'd2:    cpu_req = 1'b0;
            default: dma_req = 1'b0;
        endcase
        @(negedge clk);
        check_output("idle_quiet", 64'({grant, mem_req, err, vid_ack, cpu_ack, dma_ack}), 64'(0));
    endtask

    initial begin
        logic [1:0]  eg;
        int          delay;
        logic [15:0] mdata, dval, erd;

        tbl[0] = '{raise:3'b010, we:1'b0, lane:1'b1, delay:2,  mdata:16'hA55A, eg:2'd2, erd:16'h00A5, eerr:1'b0, ewait:3};
        tbl[1] = '{raise:3'b110, we:1'b1, lane:1'b0, delay:0,  mdata:16'h1234, eg:2'd1, erd:16'h1234, eerr:1'b0, ewait:1};
        tbl[2] = '{raise:3'b000, we:1'b0, lane:1'b0, delay:4,  mdata:16'h00FF, eg:2'd2, erd:16'h00FF, eerr:1'b0, ewait:5};
        tbl[3] = '{raise:3'b001, we:1'b0, lane:1'b0, delay:20, mdata:16'h0000, eg:2'd3, erd:16'hFFFF, eerr:1'b1, ewait:15};
        tbl[4] = '{raise:3'b011, we:1'b0, lane:1'b1, delay:14, mdata:16'hBEEF, eg:2'd2, erd:16'h00BE, eerr:1'b0, ewait:15};
        tbl[5] = '{raise:3'b010, we:1'b0, lane:1'b0, delay:0,  mdata:16'h0077, eg:2'd2, erd:16'h0077, eerr:1'b0, ewait:1};
        tbl[6] = '{raise:3'b010, we:1'b0, lane:1'b1, delay:1,  mdata:16'h8800, eg:2'd2, erd:16'h0088, eerr:1'b0, ewait:2};
        tbl[7] = '{raise:3'b010, we:1'b0, lane:1'b0, delay:0,  mdata:16'h0011, eg:2'd2, erd:16'h0011, eerr:1'b0, ewait:1};
        tbl[8] = '{raise:3'b010, we:1'b0, lane:1'b0, delay:0,  mdata:16'hCAFE, eg:2'd3, erd:16'hCAFE, eerr:1'b0, ewait:1};
        tbl[9] = '{raise:3'b000, we:1'b0, lane:1'b0, delay:0,  mdata:16'h5566, eg:2'd2, erd:16'h0066, eerr:1'b0, ewait:1};

        #12;
        check_output("reset_ctrl", 64'({vid_ack, cpu_ack, dma_ack, mem_req, mem_we, err, grant}), 64'(0));
        check_output("reset_rdata", 64'({vid_rdata, cpu_rdata, dma_rdata}), 64'(0));
        check_output("reset_bus", 64'({mem_addr, mem_wdata}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            apply_stimulus(tbl[r].raise, tbl[r].we, AW'((r + 8) * 2) | AW'(tbl[r].lane), 8'h3C,
                           AW'(32'h100 + r), AW'(32'h200 + r));
            serve(tbl[r].eg, tbl[r].delay, tbl[r].mdata, tbl[r].eerr, tbl[r].erd, tbl[r].ewait);
        end

        // Reset arriving mid-WAIT kills the transaction; the still-held req is granted afresh.
        apply_stimulus(3'b010, 1'b0, AW'(32'h11), 8'h00, vid_addr, dma_addr);
        @(negedge clk);
        check_output("rst_pre_wait", 64'({mem_req, grant}), 64'({1'b1, 2'd2}));
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_async", 64'({mem_req, grant, vid_ack, cpu_ack, dma_ack, err}), 64'(0));
        check_output("rst_rdata", 64'({vid_rdata, cpu_rdata, dma_rdata}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        model_starve = 0;
        serve(2'd2, 1, 16'h7E81, 1'b0, 16'h007E, 2);

        for (int n = 0; n < 60; n++) begin
            apply_stimulus(3'($urandom), 1'($urandom), AW'($urandom), 8'($urandom), AW'($urandom), AW'($urandom));
            if (!(vid_req || cpu_req || dma_req)) begin
                @(negedge clk);
                check_output("rand_idle", 64'({mem_req, grant}), 64'(0));
                model_starve = 0;
                continue;
            end
            if (vid_req)
                eg = 2'd1;
            else if (cpu_req && !(dma_req && model_starve >= DMA_STARVE))
                eg = 2'd2;
            else
                eg = 2'd3;
            if (!dma_req || eg == 2'd3)
                model_starve = 0;
            else if (eg == 2'd2 && model_starve < DMA_STARVE)
                model_starve++;
            delay = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, TIMEOUT + 2));
            mdata = 16'($urandom);
            dval  = (delay < TIMEOUT) ? mdata : 16'hFFFF;
            erd   = (eg == 2'd2 && cpu_addr[0]) ? {8'h00, dval[15:8]} : dval;
            serve(eg, delay, mdata, delay >= TIMEOUT, erd, (delay < TIMEOUT) ? delay + 1 : TIMEOUT);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
